// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - two-stage pipelined barrel shifter with valid/ready handshake
// Optional rotate datapath enabled by defining SHIFTER_ROT_EN; otherwise Mode=10 acts as SRL.
module shifter_pipe #(
  parameter int WIDTH = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   Shift_In,
  input  logic [SHAMT_W-1:0] Shift_Val,
  input  logic [1:0]         Mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Shift_Out,
  output logic               Zero
);

  localparam int L1   = (SHAMT_W + 1) / 2;
  localparam int HI_W = SHAMT_W - L1;

  // Applies every barrel level whose amount bit is set; callers mask the levels each stage owns.
  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0]   x,
    input logic [SHAMT_W-1:0] amt,
    input logic [1:0]         md,
    input logic               sign
  );
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    int s;
    cur = x;
    for (int k = 0; k < SHAMT_W; k++) begin
      s = 1 << k;
      if (amt[k]) begin
        if (md == 2'b00) begin
          nxt = cur << s;
        end else begin
          nxt = cur >> s;
          if (md == 2'b01 && sign) nxt = nxt | ~({WIDTH{1'b1}} >> s);
`ifdef SHIFTER_ROT_EN
          if (md == 2'b10) nxt = nxt | (cur << (WIDTH - s));
`endif
        end
        cur = nxt;
      end
    end
    return cur;
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [HI_W-1:0]    amt_hi_q, amt_hi_d;
  logic [1:0]         mode_q, mode_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   shift_out_q, shift_out_d;
  logic               zero_q, zero_d;
  logic               accept, s2_load, ready_c;
  logic [WIDTH-1:0]   s2_res;

  always_comb begin
    ready_c     = !s1_valid_q || !s2_valid_q || out_ready;
    accept      = in_valid && ready_c;
    s2_load     = s1_valid_q && (!s2_valid_q || out_ready);
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s1_data_d   = s1_data_q;
    amt_hi_d    = amt_hi_q;
    mode_d      = mode_q;
    sign_d      = sign_q;
    shift_out_d = shift_out_q;
    zero_d      = zero_q;
    s2_res      = shift_levels(s1_data_q, {amt_hi_q, {L1{1'b0}}}, mode_q, sign_q);

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = shift_levels(Shift_In, {{HI_W{1'b0}}, Shift_Val[L1-1:0]}, Mode, Shift_In[WIDTH-1]);
      amt_hi_d   = Shift_Val[SHAMT_W-1:L1];
      mode_d     = Mode;
      sign_d     = Shift_In[WIDTH-1];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d  = 1'b1;
      shift_out_d = s2_res;
      zero_d      = (s2_res == '0);
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      shift_out_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      shift_out_q <= shift_out_d;
      zero_q      <= zero_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
    amt_hi_q  <= amt_hi_d;
    mode_q    <= mode_d;
    sign_q    <= sign_d;
  end

  assign in_ready  = ready_c;
  assign out_valid = s2_valid_q;
  assign Shift_Out = shift_out_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - self-checking bench for shifter_pipe (WIDTH=16)
// Expected ROR results follow SHIFTER_ROT_EN.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic [1:0]  Mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Shift_Out;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  shifter_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Shift_In(Shift_In), .Shift_Val(Shift_Val), .Mode(Mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .Shift_Out(Shift_Out), .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int amt, input logic [1:0] md);
    logic [15:0] r;
    case (md)
      2'b00: r = x << amt;
      2'b01: r = $signed(x) >>> amt;
`ifdef SHIFTER_ROT_EN
      2'b10: r = (x >> amt) | (x << (16 - amt));
`else
      2'b10: r = x >> amt;
`endif
      default: r = x >> amt;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input logic [15:0] x, input logic [3:0] amt, input logic [1:0] md,
                          output logic [15:0] res, output logic z, output int lat);
    in_valid = 1'b1; Shift_In = x; Shift_Val = amt; Mode = md; out_ready = 1'b1;
    #1;
    tick();
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    res = Shift_Out;
    z = Zero;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Shift_In = '0; Shift_Val = '0; Mode = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Shift_Out !== 16'h0 || Zero !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out_valid=%b Shift_Out=%h Zero=%b in_ready=%b, want 0 0000 0 1",
               out_valid, Shift_Out, Zero, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] vin [9];
    logic [3:0]  vamt [9];
    logic [1:0]  vmd [9];
    logic [15:0] vexp [9];
    logic [15:0] res;
    logic        z;
    int          lat;
    vin[0] = 16'h0001; vamt[0] = 4'd15; vmd[0] = 2'b00; vexp[0] = 16'h8000;
    vin[1] = 16'h8001; vamt[1] = 4'd1;  vmd[1] = 2'b00; vexp[1] = 16'h0002;
    vin[2] = 16'h8000; vamt[2] = 4'd15; vmd[2] = 2'b01; vexp[2] = 16'hFFFF;
    vin[3] = 16'h8000; vamt[3] = 4'd4;  vmd[3] = 2'b11; vexp[3] = 16'h0800;
    vin[4] = 16'h7FF0; vamt[4] = 4'd4;  vmd[4] = 2'b01; vexp[4] = 16'h07FF;
    vin[5] = 16'hA5C3; vamt[5] = 4'd0;  vmd[5] = 2'b01; vexp[5] = 16'hA5C3;
    vin[6] = 16'hA5C3; vamt[6] = 4'd0;  vmd[6] = 2'b10; vexp[6] = 16'hA5C3;
`ifdef SHIFTER_ROT_EN
    vin[7] = 16'h0001; vamt[7] = 4'd1;  vmd[7] = 2'b10; vexp[7] = 16'h8000;
    vin[8] = 16'h1234; vamt[8] = 4'd8;  vmd[8] = 2'b10; vexp[8] = 16'h3412;
`else
    vin[7] = 16'h0001; vamt[7] = 4'd1;  vmd[7] = 2'b10; vexp[7] = 16'h0000;
    vin[8] = 16'h1234; vamt[8] = 4'd8;  vmd[8] = 2'b10; vexp[8] = 16'h0012;
`endif
    for (int i = 0; i < 9; i++) begin
      run_beat(vin[i], vamt[i], vmd[i], res, z, lat);
      checks++;
      if (res !== vexp[i] || z !== (vexp[i] == 16'h0) || lat != 2) begin
        errors++;
        $display("FAIL directed[%0d]: got %h zero=%b lat=%0d, want %h zero=%b lat=2",
                 i, res, z, lat, vexp[i], (vexp[i] == 16'h0));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] bx [3];
    logic [15:0] got [$];
    int          first_c, last_c;
    bx[0] = 16'h1111; bx[1] = 16'h2222; bx[2] = 16'h4444;
    out_ready = 1'b0; Mode = 2'b00; Shift_Val = 4'd1;
    in_valid = 1'b1; Shift_In = bx[0];
    #1;
    tick();
    Shift_In = bx[1];
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept_b: in_ready=%b want 1", in_ready);
    end
    tick();
    Shift_In = bx[2];
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || Shift_Out !== ref_shift(bx[0], 1, 2'b00)) begin
        errors++;
        $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b Shift_Out=%h, want 0 1 %h",
                 c, in_ready, out_valid, Shift_Out, ref_shift(bx[0], 1, 2'b00));
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready=%b want 1", in_ready);
    end
    first_c = -1; last_c = -1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready) begin
        got.push_back(Shift_Out);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
      in_valid = 1'b0;
      #1;
    end
    checks++;
    if (got.size() != 3 || last_c - first_c != 2) begin
      errors++;
      $display("FAIL bp_count: outputs=%0d span=%0d, want 3 2", got.size(), last_c - first_c);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== ref_shift(bx[i], 1, 2'b00)) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], ref_shift(bx[i], 1, 2'b00));
        end
      end
    end
  endtask

  task automatic test_streaming();
    logic [15:0] q [$];
    logic [15:0] e;
    int          sent = 0, recv = 0, cyc = 0;
    while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      Shift_In  = 16'($urandom);
      Shift_Val = 4'($urandom_range(0, 15));
      Mode      = 2'($urandom_range(0, 3));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected beat %h", Shift_Out);
        end else begin
          e = q.pop_front();
          if (Shift_Out !== e || Zero !== (e == 16'h0)) begin
            errors++;
            $display("FAIL stream[%0d]: got %h zero=%b want %h zero=%b", recv, Shift_Out, Zero, e, (e == 16'h0));
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_shift(Shift_In, int'(Shift_Val), Mode));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 100 || q.size() != 0) begin
      errors++; $display("FAIL stream_total: received=%0d pending=%0d, want 100 0", recv, q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [$];
    logic [15:0] e;
    int          acc = 0, recv = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_valid  = (c < 20);
      Shift_In  = 16'($urandom);
      Shift_Val = 4'($urandom_range(0, 15));
      Mode      = 2'($urandom_range(0, 3));
      #1;
      if (out_valid) begin
        e = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
        checks++;
        if (Shift_Out !== e) begin
          errors++; $display("FAIL b2b[%0d]: got %h want %h", recv, Shift_Out, e);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_shift(Shift_In, int'(Shift_Val), Mode));
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 20 || recv != 20) begin
      errors++; $display("FAIL b2b_throughput: accepted=%0d received=%0d, want 20 20", acc, recv);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b0; Mode = 2'b11; Shift_Val = 4'd2;
    in_valid = 1'b1; Shift_In = 16'hF0F0;
    #1; tick();
    Shift_In = 16'h0F0F;
    #1; tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1; Shift_In = 16'h1234;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || Shift_Out !== 16'h0 || Zero !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: out_valid=%b Shift_Out=%h Zero=%b in_ready=%b, want 0 0000 0 1",
               out_valid, Shift_Out, Zero, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rstmid_stale: stale beats=%0d want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
